// File: rtl/switch_scan_pkg.sv
// Shared constants, FSM state encoding and default parameters for the switch scanner.
package switch_scan_pkg;

    localparam int CNT_W = 8;

    localparam int DEF_NUM_SW      = 4;
    localparam int DEF_SAMPLE_DIV  = 16;
    localparam int DEF_PRESS_COUNT = 5;
    localparam int DEF_HOLD_COUNT  = 50;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE   = 2'd0;
    localparam scan_state_t ST_SAMPLE = 2'd1;
    localparam scan_state_t ST_UPDATE = 2'd2;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample tick divider: counts 0..SAMPLE_DIV-1 while enabled, one-cycle tick on the last count.
module sample_tick_gen
    import switch_scan_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (!enable) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = enable && (div_q == DIV_LAST);

endmodule

// File: rtl/switch_scan_controller.sv
// Time-multiplexed debouncer for NUM_SW active-low switches sharing one 8-bit counter.
// Optional long-press detection is built only when SWITCH_SCAN_LONG_PRESS_EN is defined.
module switch_scan_controller
    import switch_scan_pkg::*;
#(
    parameter int NUM_SW      = DEF_NUM_SW,
    parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
    parameter int PRESS_COUNT = DEF_PRESS_COUNT,
    parameter int HOLD_COUNT  = DEF_HOLD_COUNT,
    localparam int IDX_W      = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              scan_en,
    input  logic [NUM_SW-1:0] switchin,
    output logic [NUM_SW-1:0] ispressed,
    output logic [NUM_SW-1:0] enabled,
    output logic [NUM_SW-1:0] press_pulse,
    output logic [NUM_SW-1:0] release_pulse,
    output logic [NUM_SW-1:0] long_press,
    output logic [IDX_W-1:0]  scan_idx
);

    if (SAMPLE_DIV < 4 || PRESS_COUNT < 1 || PRESS_COUNT > 254 ||
        HOLD_COUNT <= PRESS_COUNT || HOLD_COUNT > 255) begin : g_bad_params
        $error("switch_scan_controller: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] PRESS_CNT = CNT_W'(PRESS_COUNT);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SW - 1);

    logic tick;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (scan_en),
        .tick    (tick)
    );

    // Synchronizer flops reset to 1 so a reset never looks like a press.
    logic [NUM_SW-1:0] sync1_q;
    logic [NUM_SW-1:0] sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= switchin;
            sync2_q <= sync1_q;
        end
    end

    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q [NUM_SW];
    logic [CNT_W-1:0]  count_d [NUM_SW];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              smp_q, smp_d;
    logic [CNT_W-1:0]  new_cnt;
    logic [NUM_SW-1:0] ispressed_q, ispressed_d;
    logic [NUM_SW-1:0] enabled_q, enabled_d;
    logic [NUM_SW-1:0] press_q, press_d;
    logic [NUM_SW-1:0] release_q, release_d;
    logic [NUM_SW-1:0] long_q, long_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        smp_d       = smp_q;
        ispressed_d = ispressed_q;
        enabled_d   = enabled_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        new_cnt     = smp_q ? sat_inc(cnt_q) : '0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                cnt_d   = count_q[idx_q];
                smp_d   = ~sync2_q[idx_q];
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                count_d[idx_q] = new_cnt;
                if (new_cnt == PRESS_CNT) begin
                    ispressed_d[idx_q] = 1'b1;
                    enabled_d[idx_q]   = ~enabled_q[idx_q];
                    press_d[idx_q]     = 1'b1;
                end
                if (new_cnt == '0 && ispressed_q[idx_q]) begin
                    ispressed_d[idx_q] = 1'b0;
                    release_d[idx_q]   = 1'b1;
                end
`ifdef SWITCH_SCAN_LONG_PRESS_EN
                if (new_cnt == CNT_W'(HOLD_COUNT)) begin
                    long_d[idx_q] = 1'b1;
                end
`endif
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Asynchronous reset abandons any in-flight update and restarts the scan at switch 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            count_q     <= '{default: '0};
            cnt_q       <= '0;
            smp_q       <= 1'b0;
            ispressed_q <= '0;
            enabled_q   <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            smp_q       <= smp_d;
            ispressed_q <= ispressed_d;
            enabled_q   <= enabled_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign ispressed     = ispressed_q;
    assign enabled       = enabled_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign scan_idx      = idx_q;

endmodule
